// File: rtl/vfd_pkg.sv
// rtl/vfd_pkg.sv - shared VFD frame geometry, host command codes and writer FSM states
package vfd_pkg;

   localparam int VFD_COLS      = 77;
   localparam int VFD_ROWS      = 39;
   localparam int VFD_MEM_DEPTH = VFD_COLS * VFD_ROWS;

   localparam logic [7:0] CMD_WRITE_FRAME = 8'h01;
   localparam logic [7:0] CMD_WRITE_AT    = 8'h02;
   localparam logic [7:0] CMD_CLEAR       = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR_HI,
      ADDR_LO,
      DATA,
      CLEAR,
      DRAIN
   } fsm_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - host SPI pin synchronizers, SCS/SSCK edge detect and byte assembly
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ssi,
   input  logic       ssck,
   input  logic       scs,
   output logic       scs_level,
   output logic       scs_rise,
   output logic       scs_fall,
   output logic       byte_rdy,
   output logic [7:0] byte_data
);

   logic [SYNC_STAGES-1:0] ssi_sync;
   logic [SYNC_STAGES-1:0] ssck_sync;
   logic [SYNC_STAGES-1:0] scs_sync;
   logic                   ssck_prev;
   logic                   scs_prev;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift_q;
   logic                   ssi_s;
   logic                   ssck_s;
   logic                   ssck_rise;

   assign ssi_s     = ssi_sync[SYNC_STAGES-1];
   assign ssck_s    = ssck_sync[SYNC_STAGES-1];
   assign scs_level = scs_sync[SYNC_STAGES-1];
   assign ssck_rise = ssck_s & ~ssck_prev;
   assign scs_rise  = scs_level & ~scs_prev;
   assign scs_fall  = ~scs_level & scs_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         ssi_sync  <= '0;
         ssck_sync <= '0;
         scs_sync  <= '1;
         ssck_prev <= 1'b0;
         scs_prev  <= 1'b1;
         bit_cnt   <= 3'd0;
         shift_q   <= 8'h00;
         byte_rdy  <= 1'b0;
         byte_data <= 8'h00;
      end else begin
         ssi_sync  <= SYNC_STAGES'({ssi_sync, ssi});
         ssck_sync <= SYNC_STAGES'({ssck_sync, ssck});
         scs_sync  <= SYNC_STAGES'({scs_sync, scs});
         ssck_prev <= ssck_s;
         scs_prev  <= scs_level;
         byte_rdy  <= 1'b0;
         // A deselected bus holds the counter at zero, dropping any partial byte.
         if (scs_level) begin
            bit_cnt <= 3'd0;
         end else if (ssck_rise) begin
            shift_q <= {shift_q[6:0], ssi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_rdy  <= 1'b1;
               byte_data <= {shift_q[6:0], ssi_s};
            end
         end
      end
   end

endmodule

// File: rtl/fb_spi_writer.sv
// rtl/fb_spi_writer.sv - host SPI command decoder writing bytes into the VFD frame RAM
module fb_spi_writer
   import vfd_pkg::*;
#(
   parameter int MEM_DEPTH   = VFD_MEM_DEPTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SSI,
   input  logic        SSCK,
   input  logic        SCS,
   output logic        WR_EN,
   output logic [11:0] WR_ADDR,
   output logic [7:0]  WR_DATA,
   output logic        BUSY,
   output logic        FRAME_DONE,
   output logic        ERR
);

   localparam logic [11:0] DEPTH = 12'(MEM_DEPTH);

   logic        scs_level;
   logic        scs_rise;
   logic        scs_fall;
   logic        byte_rdy;
   logic [7:0]  byte_data;

   fsm_state_t  state_q, state_d;
   logic [11:0] addr_q, addr_d;
   logic        frame_q, frame_d;
   logic        wr_en_d;
   logic [11:0] wr_addr_d;
   logic [7:0]  wr_data_d;
   logic        busy_d;
   logic        done_d;
   logic        err_d;
   logic [11:0] addr_in;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (CLK),
      .rst       (RST),
      .ssi       (SSI),
      .ssck      (SSCK),
      .scs       (SCS),
      .scs_level (scs_level),
      .scs_rise  (scs_rise),
      .scs_fall  (scs_fall),
      .byte_rdy  (byte_rdy),
      .byte_data (byte_data)
   );

   assign addr_in = {addr_q[11:8], byte_data};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         addr_q     <= 12'd0;
         frame_q    <= 1'b0;
         WR_EN      <= 1'b0;
         WR_ADDR    <= 12'd0;
         WR_DATA    <= 8'h00;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
         ERR        <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         frame_q    <= frame_d;
         WR_EN      <= wr_en_d;
         WR_ADDR    <= wr_addr_d;
         WR_DATA    <= wr_data_d;
         BUSY       <= busy_d;
         FRAME_DONE <= done_d;
         ERR        <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      frame_d   = frame_q;
      wr_en_d   = 1'b0;
      wr_addr_d = WR_ADDR;
      wr_data_d = WR_DATA;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (scs_fall) state_d = CMD;
         end
         CMD: begin
            if (byte_rdy) begin
               case (byte_data)
                  CMD_WRITE_FRAME: begin
                     addr_d  = 12'd0;
                     frame_d = 1'b1;
                     state_d = DATA;
                  end
                  CMD_WRITE_AT: state_d = ADDR_HI;
                  CMD_CLEAR: begin
                     addr_d  = 12'd0;
                     state_d = CLEAR;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = DRAIN;
                  end
               endcase
            end
         end
         ADDR_HI: begin
            if (byte_rdy) begin
               addr_d  = {byte_data[3:0], addr_q[7:0]};
               state_d = ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (byte_rdy) begin
               if (addr_in >= DEPTH) begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end else begin
                  addr_d  = addr_in;
                  frame_d = 1'b0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (byte_rdy) begin
               if (addr_q == DEPTH) begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = byte_data;
                  addr_d    = addr_q + 12'd1;
               end
            end
            // addr_d already counts a byte landing in this same cycle.
            if (scs_rise && frame_q && state_d == DATA && addr_d == DEPTH) done_d = 1'b1;
         end
         CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = 8'h00;
            busy_d    = 1'b1;
            addr_d    = addr_q + 12'd1;
            if (byte_rdy) err_d = 1'b1;
            // The deassert edge may have passed during the fill, so test the level.
            if (addr_q == DEPTH - 12'd1) state_d = scs_level ? IDLE : DRAIN;
         end
         DRAIN: ;
         default: state_d = IDLE;
      endcase

      if (scs_rise && state_q != CLEAR) state_d = IDLE;
   end

endmodule
